// File: rtl/mmm_mac_seq.sv
// Matrix-multiply sequencer: walks C = A x B one output element at a time,
// issuing operand reads, MAC clear/valid strobes and result write-backs.
module mmm_mac_seq #(
   parameter int DIMW    = 8,
   parameter int AW      = 16,
   parameter int MEM_LAT = 1,
   parameter int OUTW    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [DIMW-1:0] cfg_m,
   input  logic [DIMW-1:0] cfg_n,
   input  logic [DIMW-1:0] cfg_k,
   input  logic [AW-1:0]   cfg_a_base,
   input  logic [AW-1:0]   cfg_b_base,
   input  logic [AW-1:0]   cfg_c_base,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            a_rd_en,
   output logic            b_rd_en,
   output logic [AW-1:0]   a_addr,
   output logic [AW-1:0]   b_addr,
   output logic            mac_clear,
   output logic            mac_valid,
   input  logic [OUTW-1:0] mac_out,
   output logic            c_wr_en,
   output logic [AW-1:0]   c_addr,
   output logic [OUTW-1:0] c_wdata
);
   localparam int DRW = $clog2(MEM_LAT + 2);
   localparam logic [DIMW-1:0] D_ONE = DIMW'(1);
   localparam logic [AW-1:0]   A_ONE = AW'(1);
   localparam logic [DRW-1:0]  R_ONE = DRW'(1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [DIMW-1:0]   m_q, m_d, n_q, n_d, k_q, k_d;
   logic [DIMW-1:0]   i_q, i_d, j_q, j_d, kc_q, kc_d;
   logic [DRW-1:0]    drn_q, drn_d;
   logic [AW-1:0]     a_row_q, a_row_d, b_base_q, b_base_d, b_col_q, b_col_d;
   logic [AW-1:0]     c_ptr_q, c_ptr_d, a_addr_q, a_addr_d, b_addr_q, b_addr_d;
   logic              rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              clr_q, clr_d, wr_q, wr_d;
   logic [MEM_LAT-1:0] vld_q, vld_d;
   logic [MEM_LAT:0]  vld_line;
   logic              last_j, last_i;

   assign vld_line = {vld_q, rd_en_q};
   assign last_j   = (j_q == n_q - D_ONE);
   assign last_i   = (i_q == m_q - D_ONE);

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      n_d      = n_q;
      k_d      = k_q;
      i_d      = i_q;
      j_d      = j_q;
      kc_d     = kc_q;
      drn_d    = drn_q;
      a_row_d  = a_row_q;
      b_base_d = b_base_q;
      b_col_d  = b_col_q;
      c_ptr_d  = c_ptr_q;
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q;
      rd_en_d  = rd_en_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      clr_d    = 1'b0;
      wr_d     = 1'b0;
      vld_d    = vld_line[MEM_LAT-1:0];
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d      = cfg_m;
               n_d      = cfg_n;
               k_d      = cfg_k;
               i_d      = '0;
               j_d      = '0;
               a_row_d  = cfg_a_base;
               b_base_d = cfg_b_base;
               b_col_d  = cfg_b_base;
               c_ptr_d  = cfg_c_base;
               if (cfg_m == '0 || cfg_n == '0 || cfg_k == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_CLEAR;
                  clr_d   = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            state_d  = S_FEED;
            rd_en_d  = 1'b1;
            kc_d     = '0;
            a_addr_d = a_row_q;
            b_addr_d = b_col_q;
         end
         S_FEED: begin
            if (kc_q == k_q - D_ONE) begin
               state_d = S_DRAIN;
               rd_en_d = 1'b0;
               drn_d   = '0;
            end else begin
               // A walks along its row, B walks down its column
               kc_d     = kc_q + D_ONE;
               a_addr_d = a_addr_q + A_ONE;
               b_addr_d = b_addr_q + AW'(n_q);
            end
         end
         S_DRAIN: begin
            if (drn_q == DRW'(MEM_LAT)) begin
               state_d = S_WRITE;
               wr_d    = 1'b1;
            end else begin
               drn_d = drn_q + R_ONE;
            end
         end
         S_WRITE: begin
            c_ptr_d = c_ptr_q + A_ONE;
            if (last_j) begin
               j_d     = '0;
               i_d     = i_q + D_ONE;
               b_col_d = b_base_q;
               a_row_d = a_row_q + AW'(k_q);
            end else begin
               j_d     = j_q + D_ONE;
               b_col_d = b_col_q + A_ONE;
            end
            if (last_i && last_j) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = S_CLEAR;
               clr_d   = 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         kc_q     <= '0;
         drn_q    <= '0;
         a_row_q  <= '0;
         b_base_q <= '0;
         b_col_q  <= '0;
         c_ptr_q  <= '0;
         a_addr_q <= '0;
         b_addr_q <= '0;
         rd_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         clr_q    <= 1'b0;
         wr_q     <= 1'b0;
         vld_q    <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         n_q      <= n_d;
         k_q      <= k_d;
         i_q      <= i_d;
         j_q      <= j_d;
         kc_q     <= kc_d;
         drn_q    <= drn_d;
         a_row_q  <= a_row_d;
         b_base_q <= b_base_d;
         b_col_q  <= b_col_d;
         c_ptr_q  <= c_ptr_d;
         a_addr_q <= a_addr_d;
         b_addr_q <= b_addr_d;
         rd_en_q  <= rd_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         clr_q    <= clr_d;
         wr_q     <= wr_d;
         vld_q    <= vld_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign a_rd_en   = rd_en_q;
   assign b_rd_en   = rd_en_q;
   assign a_addr    = a_addr_q;
   assign b_addr    = b_addr_q;
   assign mac_clear = clr_q;
   assign mac_valid = vld_q[MEM_LAT-1];
   assign c_wr_en   = wr_q;
   assign c_addr    = c_ptr_q;
   // accumulator settles in the write cycle itself, so pass it straight through
   assign c_wdata   = wr_q ? mac_out : '0;
endmodule
